neosd_card_cmd: RTL and testbench
=================================

// Module: neosd_card_cmd
// PURPOSE
//  Card-side (device) endpoint of the SD CMD line: the responder to the host CMD FSM.
//  Receives 48-bit command frames clocked by the host SD clock and checks start, transmission and end bits plus CRC7.
//  Presents index and argument to card-model logic, then serialises its 48- or 136-bit response back after NCR cycles.
//  Used as the card model in the SD system bench and in FPGA SD-card emulation; all logic runs in the clk_i domain.
// PARAMETERS
//  NCR_CYCLES    2    SD clocks between command end bit and response start bit (2..64)
//  RESP_TIMEOUT  64   SD clocks to wait for resp_valid_i before dropping the response (>= NCR_CYCLES)
// PORTS
//  clk_i          in   1    system clock; must be >= 4x sd_clk_i frequency
//  rstn_i         in   1    asynchronous reset, active-low
//  sd_clk_i       in   1    SD clock from host (asynchronous, 2-FF synchronised internally)
//  sd_cmd_i       in   1    CMD line input
//  sd_cmd_o       out  1    CMD line output data
//  sd_cmd_oe      out  1    CMD line output enable
//  cmd_valid_o    out  1    1-cycle pulse: good command received
//  cmd_idx_o      out  6    command index, held until next good command
//  cmd_arg_o      out  32   command argument, held until next good command
//  cmd_err_o      out  1    1-cycle pulse: framing or CRC error, command discarded
//  resp_ready_o   out  1    high while a response is accepted (WAIT state)
//  resp_valid_i   in   1    response request; accepted when valid && ready
//  resp_type_i    in   2    00 none, 01 R48+CRC, 10 R48 CRC field 7'h7F (R3), 11 R136 (R2)
//  resp_data_i    in   120  R48: [37:32] index, [31:0] arg; R136: CID/CSD bits [127:8]
// BEHAVIOUR
//  Reset: sd_cmd_oe=0, sd_cmd_o=1, all pulses/ready 0, cmd_idx_o=0, cmd_arg_o=0, FSM IDLE.
//  sd_clk_i goes through a 2-FF sync; rise/fall strobes come from comparing the last two synced samples.
//  CMD is sampled on rise strobes; outputs change only on fall strobes.
//  CRC7 polynomial x^7+x^3+1, init 0. Computed over the first 40 bits (R48) or the 120 content bits (R136).
//  FSM:
//   IDLE: a rise strobe sampling sd_cmd_i=0 goes to RX; bit counter := 1.
//   RX: shift 47 more bits; after bit 48 go to CHECK.
//   CHECK (1 clk): transmission bit==1, end bit==1 and CRC match all pass:
//     latch idx/arg, pulse cmd_valid_o, go to WAIT with ncr counter cleared.
//     Any failure: pulse cmd_err_o and go to IDLE.
//   WAIT: resp_ready_o=1; count rise strobes.
//     Accept type 00 -> IDLE.
//     Accept type != 00 -> build shift register, go to DLY.
//       R48 frame: {0,0,idx,arg,crc7,1}.
//       R136 frame: {0,0,6'h3F,data,crc7,1}.
//     Count reaches RESP_TIMEOUT with no accept -> IDLE silently.
//     sd_cmd_i=0 on a rise strobe in WAIT (host re-issued a command) -> RX; the old response is dropped.
//   DLY: once the rise-strobe count since the end bit reaches NCR_CYCLES, the next fall strobe drives the start bit, sets oe=1 and goes to TX.
//     An accept that arrives later than NCR starts on the first fall strobe after the accept.
//   TX: shift one bit per fall strobe, MSB first; the bit counter stops at 48/136.
//     The fall strobe after the end bit sets oe=0, sd_cmd_o=1 and returns to IDLE.
//     sd_cmd_i is ignored in DLY and TX.
//  Simultaneous rise strobe and accept in WAIT: the accept wins; that strobe still counts toward NCR.
//  sd_clk_i stopped by the host: FSM holds its state (there is no clk_i-based timeout).
//  rstn_i low mid-frame: immediate return to reset values; the partial frame is lost.
// TESTING
//  CMD8 frame 48'h48000001AA87 -> cmd_valid_o pulse, idx=8, arg=32'h1AA, no cmd_err_o.
//    Reply type 01, data {6'd8,32'h1AA} -> line 48'h08000001AA13.
//    The start bit is driven on the fall strobe following the 2nd rise strobe after the end bit.
//  CMD0 frame 48'h400000000097 (bad CRC, good=95) -> cmd_err_o pulse, no cmd_valid_o, resp_ready_o stays 0, oe stays 0.
//  R2 reply (type 11), data=120'h0123...EF pattern -> 136 bits on line.
//    First byte 8'h3F, CRC7 matches a reference model, last bit 1, oe high exactly 136 SD clocks.
//  R3 reply to CMD41: type 10, data {6'h3F,32'h80FF8000} -> line 48'h3F80FF8000FF.
//  No resp_valid_i for 64 SD clocks after CMD17 (48'h510000000055) -> back to IDLE, oe never set.
//    A following CMD8 is accepted normally.
//  rstn_i pulsed low during TX bit 20 -> oe=0, sd_cmd_o=1 in the same cycle.
//    After release, a new CMD8 is decoded correctly.

Source files
------------

// File: rtl/neosd_card_cmd_if.sv
// Card-model side bundle of the SD card CMD endpoint.
// Decoded command out (valid/err pulses, idx/arg) and response request in.
interface neosd_card_cmd_if;
  logic         cmd_valid_o;
  logic [5:0]   cmd_idx_o;
  logic [31:0]  cmd_arg_o;
  logic         cmd_err_o;
  logic         resp_ready_o;
  logic         resp_valid_i;
  logic [1:0]   resp_type_i;
  logic [119:0] resp_data_i;

  modport slave (
    output cmd_valid_o, cmd_idx_o, cmd_arg_o,
    output cmd_err_o, resp_ready_o,
    input  resp_valid_i, resp_type_i, resp_data_i
  );

  modport master (
    input  cmd_valid_o, cmd_idx_o, cmd_arg_o,
    input  cmd_err_o, resp_ready_o,
    output resp_valid_i, resp_type_i, resp_data_i
  );
endinterface

// File: rtl/neosd_card_cmd.sv
// SD CMD line card endpoint: receives/checks 48-bit commands, sends R48/R136.
// Ports: clk_i, rstn_i (async low), sd_clk_i, sd_cmd_i, sd_cmd_o, sd_cmd_oe, bus.
module neosd_card_cmd #(
  parameter int NCR_CYCLES   = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic sd_clk_i,
  input  logic sd_cmd_i,
  output logic sd_cmd_o,
  output logic sd_cmd_oe,
  neosd_card_cmd_if.slave bus
);

  localparam int CW = $clog2(RESP_TIMEOUT + 2);
  localparam logic [CW-1:0] NCR_C = CW'(NCR_CYCLES);
  localparam logic [CW-1:0] TO_C  = CW'(RESP_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_CHECK, S_WAIT, S_DLY, S_TX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]    r_clk_sync;
  logic          w_rise;
  logic          w_fall;
  logic [7:0]    r_bitcnt;
  logic [47:0]   r_rx_sr;
  logic [135:0]  r_tx_sr;
  logic          r_tx_long;
  logic [CW-1:0] r_cnt;
  logic          r_cmd_o;
  logic          r_cmd_oe;
  logic [5:0]    r_idx;
  logic [31:0]   r_arg;
  logic          r_valid;
  logic          r_err;

  logic          w_accept;
  logic          w_chk_ok;
  logic          w_tx_last;
  logic [6:0]    w_rx_crc;
  logic [6:0]    w_r48_crc;
  logic [6:0]    w_r136_crc;
  logic [135:0]  w_tx_frame;

  // Leading zeros do not change a zero-initialised CRC, so a
  // 40-bit message is handled by zero-padding it to 120 bits.
  function automatic logic [6:0] crc7(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // [1] is the synchronised level, [2] the previous one
  assign w_rise = r_clk_sync[1] & ~r_clk_sync[2];
  assign w_fall = ~r_clk_sync[1] & r_clk_sync[2];

  assign w_accept = (r_state == S_WAIT) & bus.resp_valid_i;
  assign w_rx_crc = crc7({80'b0, r_rx_sr[47:8]});
  assign w_chk_ok = ~r_rx_sr[47] & r_rx_sr[46] & r_rx_sr[0]
                  & (r_rx_sr[7:1] == w_rx_crc);
  assign w_tx_last = r_tx_long ? (r_bitcnt == 8'd136)
                               : (r_bitcnt == 8'd48);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_rise && !sd_cmd_i) w_next = S_RX;
      S_RX:
        if (w_rise && r_bitcnt == 8'd47) w_next = S_CHECK;
      S_CHECK:
        w_next = w_chk_ok ? S_WAIT : S_IDLE;
      S_WAIT:
        if (w_accept)
          w_next = (bus.resp_type_i == 2'b00) ? S_IDLE : S_DLY;
        else if (w_rise && !sd_cmd_i)
          w_next = S_RX;
        else if (r_cnt >= TO_C)
          w_next = S_IDLE;
      S_DLY:
        if (w_fall && r_cnt >= NCR_C) w_next = S_TX;
      S_TX:
        if (w_fall && w_tx_last) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_r48_crc  = crc7({80'b0, 2'b00, bus.resp_data_i[37:0]});
    if (bus.resp_type_i == 2'b10) w_r48_crc = 7'h7F;
    w_r136_crc = crc7(bus.resp_data_i);
    if (bus.resp_type_i == 2'b11)
      w_tx_frame = {2'b00, 6'h3F, bus.resp_data_i,
                    w_r136_crc, 1'b1};
    else
      w_tx_frame = {2'b00, bus.resp_data_i[37:0],
                    w_r48_crc, 1'b1, 88'b0};
    bus.resp_ready_o = (r_state == S_WAIT);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_clk_sync <= '0;
      r_bitcnt   <= '0;
      r_rx_sr    <= '0;
      r_tx_sr    <= '0;
      r_tx_long  <= 1'b0;
      r_cnt      <= '0;
      r_cmd_o    <= 1'b1;
      r_cmd_oe   <= 1'b0;
      r_idx      <= '0;
      r_arg      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], sd_clk_i};
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_rise && !sd_cmd_i) begin
            r_rx_sr  <= '0;
            r_bitcnt <= 8'd1;
          end
        end
        S_RX: begin
          if (w_rise) begin
            r_rx_sr  <= {r_rx_sr[46:0], sd_cmd_i};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_chk_ok) begin
            r_idx   <= r_rx_sr[45:40];
            r_arg   <= r_rx_sr[39:8];
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_err   <= 1'b1;
          end
        end
        S_WAIT: begin
          // a strobe coinciding with the accept still counts
          if (w_rise && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (w_accept) begin
            r_tx_sr   <= w_tx_frame;
            r_tx_long <= (bus.resp_type_i == 2'b11);
          end else if (w_rise && !sd_cmd_i) begin
            r_rx_sr  <= '0;
            r_bitcnt <= 8'd1;
          end
        end
        S_DLY: begin
          if (w_rise && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (w_fall && r_cnt >= NCR_C) begin
            r_cmd_o  <= r_tx_sr[135];
            r_tx_sr  <= {r_tx_sr[134:0], 1'b0};
            r_cmd_oe <= 1'b1;
            r_bitcnt <= 8'd1;
          end
        end
        S_TX: begin
          if (w_fall) begin
            if (w_tx_last) begin
              r_cmd_oe <= 1'b0;
              r_cmd_o  <= 1'b1;
            end else begin
              r_cmd_o  <= r_tx_sr[135];
              r_tx_sr  <= {r_tx_sr[134:0], 1'b0};
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sd_cmd_o        = r_cmd_o;
  assign sd_cmd_oe       = r_cmd_oe;
  assign bus.cmd_valid_o = r_valid;
  assign bus.cmd_err_o   = r_err;
  assign bus.cmd_idx_o   = r_idx;
  assign bus.cmd_arg_o   = r_arg;

endmodule

// File: tb/tb_neosd_card_cmd.sv
// Self-checking bench for neosd_card_cmd: acts as SD host and card model.
// Table of command/response vectors plus re-issue and mid-TX reset cases.
module tb_neosd_card_cmd;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic sd_clk_i = 1'b0;
  logic sd_cmd_i = 1'b1;
  logic sd_cmd_o;
  logic sd_cmd_oe;
  logic auto_resp = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_ready = 0;

  logic rec_line [200];
  logic rec_oe [200];

  neosd_card_cmd_if bus();

  neosd_card_cmd #(
    .NCR_CYCLES(2),
    .RESP_TIMEOUT(64)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .sd_clk_i(sd_clk_i),
    .sd_cmd_i(sd_cmd_i),
    .sd_cmd_o(sd_cmd_o),
    .sd_cmd_oe(sd_cmd_oe),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  // card model: request a response as soon as ready is seen
  always @(negedge clk_i) begin
    if (auto_resp && bus.resp_ready_o) bus.resp_valid_i = 1'b1;
    else                               bus.resp_valid_i = 1'b0;
  end

  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (bus.cmd_valid_o === 1'b1) n_valid++;
      if (bus.cmd_err_o === 1'b1) n_err++;
      if (bus.resp_ready_o === 1'b1) n_ready++;
    end
  end

  // reference CRC7 by polynomial long division (x^7+x^3+1)
  function automatic logic [6:0] crc_ref(input logic [119:0] msg);
    logic [126:0] m;
    m = {msg, 7'b0};
    for (int i = 126; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx,
                                           input logic [31:0] arg);
    return {2'b01, idx, arg,
            crc_ref({80'b0, 2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic chk(input string name, input logic [135:0] act,
                     input logic [135:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one SD clock: drive while low, sample DUT late in the low phase
  task automatic sd_tick(input logic b, output logic l, output logic o);
    sd_cmd_i = b;
    #33;
    l = sd_cmd_o;
    o = sd_cmd_oe;
    #7 sd_clk_i = 1'b1;
    #40 sd_clk_i = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f, input logic arm);
    logic l, o;
    for (int i = 47; i >= 0; i--) begin
      sd_tick(f[i], l, o);
      if (i == 47) auto_resp = arm;
    end
    sd_cmd_i = 1'b1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++)
      sd_tick(1'b1, rec_line[i], rec_oe[i]);
  endtask

  task automatic analyse(input int n, input int len, output int first,
                         output int cnt, output logic [135:0] got);
    first = -1;
    cnt = 0;
    got = '0;
    for (int i = 0; i < n; i++)
      if (rec_oe[i] === 1'b1) begin
        if (first < 0) first = i;
        cnt++;
      end
    if (first >= 0)
      for (int j = 0; j < len; j++)
        if (first + j < n) got[135-j] = rec_line[first+j];
  endtask

  typedef struct {
    logic [47:0]  frame;
    logic         arm;
    logic [1:0]   rtype;
    logic [119:0] rdata;
    logic         ok;
    logic [5:0]   idx;
    logic [31:0]  arg;
    int           len;
    logic [135:0] resp;
  } vec_t;

  function automatic vec_t mkv(
    input logic [47:0] frame, input logic arm, input logic [1:0] rtype,
    input logic [119:0] rdata, input logic ok, input logic [5:0] idx,
    input logic [31:0] arg, input int len, input logic [135:0] resp);
    vec_t v;
    v.frame = frame; v.arm = arm; v.rtype = rtype; v.rdata = rdata;
    v.ok = ok; v.idx = idx; v.arg = arg; v.len = len; v.resp = resp;
    return v;
  endfunction

  localparam int NV = 9;
  localparam int NT = 150;

  initial begin
    vec_t vecs [NV];
    vec_t v;
    logic [119:0] d2;
    logic [119:0] d8;
    logic [135:0] r8;
    logic [135:0] got;
    logic [47:0] r8f;
    int nv, ne, nr, first, cnt;

    d2 = 120'h0123456789ABCDEF0123456789ABCD;
    d8 = {82'b0, 6'd8, 32'h1AA};
    r8f = 48'h08000001AA13;
    r8 = {r8f, 88'b0};

    vecs[0] = mkv(48'h48000001AA87, 1, 2'b01, d8,
                  1, 6'd8, 32'h1AA, 48, r8);
    vecs[1] = mkv(48'h400000000097, 1, 2'b01, d8,
                  0, 6'd8, 32'h1AA, 0, '0);
    vecs[2] = mkv(48'h400000000095, 1, 2'b00, d8,
                  1, 6'd0, 32'h0, 0, '0);
    vecs[3] = mkv(48'h48000001AA86, 1, 2'b01, d8,
                  0, 6'd0, 32'h0, 0, '0);
    vecs[4] = mkv(48'h08000001AA87, 1, 2'b01, d8,
                  0, 6'd0, 32'h0, 0, '0);
    vecs[5] = mkv(mk_frame(6'd41, 32'h40FF8000), 1, 2'b10,
                  {82'b0, 6'h3F, 32'h80FF8000},
                  1, 6'd41, 32'h40FF8000, 48,
                  {48'h3F80FF8000FF, 88'b0});
    vecs[6] = mkv(mk_frame(6'd2, 32'h0), 1, 2'b11, d2,
                  1, 6'd2, 32'h0, 136,
                  {8'h3F, d2, crc_ref(d2), 1'b1});
    vecs[7] = mkv(48'h510000000055, 0, 2'b01, d8,
                  1, 6'd17, 32'h0, 0, '0);
    vecs[8] = mkv(48'h48000001AA87, 1, 2'b01, d8,
                  1, 6'd8, 32'h1AA, 48, r8);

    bus.resp_type_i = 2'b00;
    bus.resp_data_i = '0;
    #23;
    chk("rst_oe", sd_cmd_oe, 0);
    chk("rst_cmd_o", sd_cmd_o, 1);
    chk("rst_ready", bus.resp_ready_o, 0);
    chk("rst_valid", bus.cmd_valid_o, 0);
    chk("rst_err", bus.cmd_err_o, 0);
    chk("rst_idx", bus.cmd_idx_o, 0);
    chk("rst_arg", bus.cmd_arg_o, 0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    #80;

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      bus.resp_type_i = v.rtype;
      bus.resp_data_i = v.rdata;
      nv = n_valid; ne = n_err; nr = n_ready;
      send_frame(v.frame, v.arm);
      run_ticks(NT);
      auto_resp = 1'b0;
      analyse(NT, v.len, first, cnt, got);
      chk($sformatf("v%0d_valid", k), n_valid - nv, v.ok ? 1 : 0);
      chk($sformatf("v%0d_err", k), n_err - ne, v.ok ? 0 : 1);
      chk($sformatf("v%0d_idx", k), bus.cmd_idx_o, v.idx);
      chk($sformatf("v%0d_arg", k), bus.cmd_arg_o, v.arg);
      chk($sformatf("v%0d_oe_clks", k), cnt, v.len);
      if (v.len > 0) begin
        chk($sformatf("v%0d_ncr_start", k), first, 2);
        chk($sformatf("v%0d_resp", k), got, v.resp);
      end
      if (!v.ok)
        chk($sformatf("v%0d_ready_on_err", k), n_ready - nr, 0);
      if (!v.arm) begin
        chk($sformatf("v%0d_timeout_len", k),
            (n_ready - nr >= 504) && (n_ready - nr <= 520), 1);
        chk($sformatf("v%0d_ready_end", k), bus.resp_ready_o, 0);
      end
    end

    // host re-issues a command while the card waits for a response
    bus.resp_type_i = 2'b01;
    bus.resp_data_i = d8;
    nv = n_valid;
    send_frame(48'h400000000095, 1'b0);
    run_ticks(4);
    send_frame(48'h48000001AA87, 1'b1);
    run_ticks(NT);
    auto_resp = 1'b0;
    analyse(NT, 48, first, cnt, got);
    chk("reissue_valid", n_valid - nv, 2);
    chk("reissue_idx", bus.cmd_idx_o, 8);
    chk("reissue_oe_clks", cnt, 48);
    chk("reissue_start", first, 2);
    chk("reissue_resp", got, r8);

    // reset asserted while response bit 20 is on the line
    send_frame(48'h48000001AA87, 1'b1);
    run_ticks(22);
    chk("tx_oe_before_rst", rec_oe[21], 1);
    chk("tx_bit20", rec_line[21], r8f[28]);
    #3 rstn_i = 1'b0;
    auto_resp = 1'b0;
    #1;
    chk("rst_tx_oe", sd_cmd_oe, 0);
    chk("rst_tx_cmd_o", sd_cmd_o, 1);
    chk("rst_tx_idx", bus.cmd_idx_o, 0);
    #20 rstn_i = 1'b1;
    @(negedge clk_i);
    nv = n_valid;
    send_frame(48'h48000001AA87, 1'b1);
    run_ticks(NT);
    auto_resp = 1'b0;
    analyse(NT, 48, first, cnt, got);
    chk("post_rst_valid", n_valid - nv, 1);
    chk("post_rst_idx", bus.cmd_idx_o, 8);
    chk("post_rst_arg", bus.cmd_arg_o, 32'h1AA);
    chk("post_rst_resp", got, r8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
